// File: rtl/core_bus_pkg.sv
// Shared definitions for the core bus responder: state encodings, default widths,
// and bit positions of the core's input-pin vector.
package core_bus_pkg;

  localparam int DEF_DATASIZE = 8;
  localparam int DEF_ADDRSIZE = 16;

  // Slices of the core ipin vector that the responder drives
  localparam int IPIN_READY = 0;
  localparam int IPIN_HOLD  = 1;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WAIT,
    DATA
  } bus_state_e;

  typedef enum logic [1:0] {
    HIDLE,
    HREQ,
    HGNT
  } hold_state_e;

endpackage

// File: rtl/core_bus_holdarb.sv
// DMA hold arbitration: raises HOLD toward the core only between bus cycles
// and grants the bus once the core acknowledges.
module core_bus_holdarb
  import core_bus_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic dma_req,
  input  logic bus_hlda,
  input  logic bus_idle,
  output logic core_hold,
  output logic dma_gnt,
  output logic in_gnt
);

  hold_state_e state_q, state_d;
  logic        hold_q, hold_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HIDLE;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // A request seen mid-cycle simply waits in HIDLE until the bus FSM is idle
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      HIDLE: begin
        if (dma_req && bus_idle) begin
          hold_d  = 1'b1;
          state_d = HREQ;
        end
      end
      HREQ: begin
        if (!dma_req) begin
          hold_d  = 1'b0;
          state_d = HIDLE;
        end else if (bus_hlda) begin
          state_d = HGNT;
        end
      end
      HGNT: begin
        if (!dma_req) begin
          hold_d  = 1'b0;
          state_d = HIDLE;
        end
      end
      default: begin
        hold_d  = 1'b0;
        state_d = HIDLE;
      end
    endcase
  end

  assign core_hold = hold_q;
  assign in_gnt    = (state_q == HGNT);
  assign dma_gnt   = in_gnt & hold_q & bus_hlda;

endmodule

// File: rtl/core_bus_responder.sv
// Memory/IO end of the 8085-style bus cycle: latches the address, inserts wait
// states through READY, moves read/write data and arbitrates DMA hold.
module core_bus_responder
  import core_bus_pkg::*;
#(
  parameter int DATASIZE = DEF_DATASIZE,
  parameter int ADDRSIZE = DEF_ADDRSIZE,
  parameter int WAIT_MEM = 0,
  parameter int WAIT_IO  = 1,
  parameter int CNTSIZE  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         bus_ale,
  input  logic                         bus_rd,
  input  logic                         bus_wr,
  input  logic                         bus_iom,
  input  logic                         bus_hlda,
  input  logic [ADDRSIZE-DATASIZE-1:0] bus_ahi,
  input  logic [DATASIZE-1:0]          bus_ad_i,
  output logic [DATASIZE-1:0]          bus_ad_o,
  output logic                         bus_ad_oe,
  output logic                         core_ready,
  output logic                         core_hold,
  output logic [ADDRSIZE-1:0]          mem_addr,
  output logic                         mem_iom,
  input  logic [DATASIZE-1:0]          mem_rdata,
  output logic [DATASIZE-1:0]          mem_wdata,
  output logic                         mem_we,
  input  logic                         dma_req,
  output logic                         dma_gnt,
  output logic                         bus_err
);

  localparam logic [CNTSIZE-1:0] W_MEM = CNTSIZE'(WAIT_MEM);
  localparam logic [CNTSIZE-1:0] W_IO  = CNTSIZE'(WAIT_IO);

  bus_state_e          state_q, state_d;
  logic [CNTSIZE-1:0]  cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                oe_q, oe_d;
  logic [ADDRSIZE-1:0] addr_q, addr_d;
  logic                iom_q, iom_d;
  logic [DATASIZE-1:0] wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic                wr_cycle_q, wr_cycle_d;
  logic [CNTSIZE-1:0]  wait_sel;
  logic                enter_data;
  logic                enter_wr;
  logic                hold_in_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b1;
      oe_q       <= 1'b0;
      addr_q     <= '0;
      iom_q      <= 1'b0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      wr_cycle_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      oe_q       <= oe_d;
      addr_q     <= addr_d;
      iom_q      <= iom_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      err_q      <= err_d;
      wr_cycle_q <= wr_cycle_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready_d    = ready_q;
    oe_d       = oe_q;
    addr_d     = addr_q;
    iom_d      = iom_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    err_d      = err_q;
    wr_cycle_d = wr_cycle_q;
    enter_data = 1'b0;
    enter_wr   = 1'b0;
    wait_sel   = iom_q ? W_IO : W_MEM;

    if (bus_ale && hold_in_gnt) err_d = 1'b1;

    // ALE always starts a fresh cycle; outside IDLE it also aborts the current one
    if (bus_ale) begin
      if (state_q != IDLE) err_d = 1'b1;
      addr_d  = {bus_ahi, bus_ad_i};
      iom_d   = bus_iom;
      ready_d = 1'b1;
      oe_d    = 1'b0;
      cnt_d   = '0;
      state_d = ADDR;
    end else begin
      case (state_q)
        ADDR: begin
          if (bus_rd || bus_wr) begin
            if (bus_rd && bus_wr) err_d = 1'b1;
            wr_cycle_d = bus_wr & ~bus_rd;
            cnt_d      = wait_sel;
            if (wait_sel != '0) begin
              ready_d = 1'b0;
              state_d = WAIT;
            end else begin
              enter_data = 1'b1;
              enter_wr   = bus_wr & ~bus_rd;
              state_d    = DATA;
            end
          end
        end
        WAIT: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNTSIZE'(1)) begin
            ready_d    = 1'b1;
            enter_data = 1'b1;
            enter_wr   = wr_cycle_q;
            state_d    = DATA;
          end
        end
        DATA: begin
          if (!bus_rd && !bus_wr) begin
            oe_d    = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (enter_data) begin
      if (enter_wr) begin
        we_d    = 1'b1;
        wdata_d = bus_ad_i;
      end else begin
        oe_d = 1'b1;
      end
    end
  end

  core_bus_holdarb u_holdarb (
    .clk       (clk),
    .rst       (rst),
    .dma_req   (dma_req),
    .bus_hlda  (bus_hlda),
    .bus_idle  (state_q == IDLE),
    .core_hold (core_hold),
    .dma_gnt   (dma_gnt),
    .in_gnt    (hold_in_gnt)
  );

  assign bus_ad_o   = oe_q ? mem_rdata : '0;
  assign bus_ad_oe  = oe_q;
  assign core_ready = ready_q;
  assign mem_addr   = addr_q;
  assign mem_iom    = iom_q;
  assign mem_wdata  = wdata_q;
  assign mem_we     = we_q;
  assign bus_err    = err_q;

endmodule

// File: tb/tb_core_bus_responder.sv
// Scoreboard bench for core_bus_responder: random bus cycles against a byte-array
// memory model, plus directed DMA, protocol-error and mid-cycle reset scenarios.
module tb_core_bus_responder;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int WM = 0;
  localparam int WI = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          bus_ale, bus_rd, bus_wr, bus_iom, bus_hlda;
  logic [AW-DW-1:0] bus_ahi;
  logic [DW-1:0] bus_ad_i, bus_ad_o;
  logic          bus_ad_oe, core_ready, core_hold;
  logic [AW-1:0] mem_addr;
  logic          mem_iom;
  logic [DW-1:0] mem_rdata, mem_wdata;
  logic          mem_we, dma_req, dma_gnt, bus_err;

  always #5 clk = ~clk;

  core_bus_responder #(
    .DATASIZE(DW), .ADDRSIZE(AW), .WAIT_MEM(WM), .WAIT_IO(WI), .CNTSIZE(4)
  ) dut (
    .clk(clk), .rst(rst),
    .bus_ale(bus_ale), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_iom(bus_iom),
    .bus_hlda(bus_hlda), .bus_ahi(bus_ahi), .bus_ad_i(bus_ad_i),
    .bus_ad_o(bus_ad_o), .bus_ad_oe(bus_ad_oe), .core_ready(core_ready),
    .core_hold(core_hold), .mem_addr(mem_addr), .mem_iom(mem_iom),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .dma_req(dma_req), .dma_gnt(dma_gnt), .bus_err(bus_err)
  );

  typedef struct {
    bit          isWrite;
    logic [15:0] addr;
    bit          iom;
    logic [7:0]  data;
    int          waits;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  bit         monEn = 1'b0;
  int         weCount = 0;
  int         lowCnt = 0;
  bit         oePrev = 1'b0;
  logic [7:0] envMem [0:131071];
  logic [7:0] refMem [int];

  // Power-on contents shared by the environment memory and the reference model
  function automatic logic [7:0] initByte(int idx);
    if (idx == 32'h01234) return 8'hA5;
    return idx[7:0] ^ idx[15:8] ^ (idx[16] ? 8'hC3 : 8'h2C);
  endfunction

  function automatic logic [7:0] refRead(int idx);
    if (refMem.exists(idx)) return refMem[idx];
    return initByte(idx);
  endfunction

  initial for (int i = 0; i < 131072; i++) envMem[i] <= initByte(i);
  assign mem_rdata = envMem[{mem_iom, mem_addr}];
  always @(posedge clk) if (mem_we) envMem[{mem_iom, mem_addr}] <= mem_wdata;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scoreEvent(input bit wrEvt);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL sb_empty: unexpected %s event at addr 0x%0h", wrEvt ? "write" : "read", mem_addr);
    end else begin
      e = sb.pop_front();
      checkOutput("sb_kind", 32'(wrEvt), 32'(e.isWrite));
      checkOutput("sb_addr", 32'(mem_addr), 32'(e.addr));
      checkOutput("sb_iom", 32'(mem_iom), 32'(e.iom));
      checkOutput(wrEvt ? "sb_wdata" : "sb_rdata", wrEvt ? 32'(mem_wdata) : 32'(bus_ad_o), 32'(e.data));
      checkOutput("sb_waits", 32'(lowCnt), 32'(e.waits));
    end
    lowCnt = 0;
  endtask

  // Monitor: counts READY-low cycles and scores each write pulse / read-enable rise
  initial forever begin
    @(negedge clk);
    if (mem_we) weCount++;
    if (!monEn || rst) begin
      lowCnt = 0;
      oePrev = bus_ad_oe;
    end else begin
      if (!core_ready) lowCnt++;
      if (mem_we) scoreEvent(1'b1);
      if (bus_ad_oe && !oePrev) scoreEvent(1'b0);
      oePrev = bus_ad_oe;
    end
  end

  // One complete bus cycle as the core would run it; expectation queued up front
  task automatic applyStimulus(input bit iom, input bit isWr, input logic [15:0] addr,
                               input logic [7:0] data, input int extra);
    exp_t e;
    int   idx;
    int   n;
    idx       = int'({iom, addr});
    e.isWrite = isWr;
    e.addr    = addr;
    e.iom     = iom;
    e.waits   = iom ? WI : WM;
    if (isWr) begin
      e.data      = data;
      refMem[idx] = data;
    end else begin
      e.data = refRead(idx);
    end
    sb.push_back(e);

    bus_ale  = 1'b1;
    bus_iom  = iom;
    bus_ahi  = addr[15:8];
    bus_ad_i = addr[7:0];
    step();
    bus_ale = 1'b0;
    if (isWr) begin
      bus_wr   = 1'b1;
      bus_ad_i = data;
    end else begin
      bus_rd = 1'b1;
    end
    n = 0;
    do begin
      step();
      n++;
    end while (!core_ready && n < 20);
    if (!core_ready) checkOutput("ready_timeout", 32'(core_ready), 32'd1);
    repeat (extra) step();
    bus_rd = 1'b0;
    bus_wr = 1'b0;
    step();
    checkOutput("oe_release", 32'(bus_ad_oe), 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, 32'(core_ready), 32'd1);
    checkOutput({tag, "_hold"}, 32'(core_hold), 32'd0);
    checkOutput({tag, "_oe"}, 32'(bus_ad_oe), 32'd0);
    checkOutput({tag, "_ad_o"}, 32'(bus_ad_o), 32'd0);
    checkOutput({tag, "_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "_iom"}, 32'(mem_iom), 32'd0);
    checkOutput({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    checkOutput({tag, "_we"}, 32'(mem_we), 32'd0);
    checkOutput({tag, "_err"}, 32'(bus_err), 32'd0);
    checkOutput({tag, "_gnt"}, 32'(dma_gnt), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wb;
    rst = 1'b1;
    bus_ale = 1'b0; bus_rd = 1'b0; bus_wr = 1'b0; bus_iom = 1'b0; bus_hlda = 1'b0;
    bus_ahi = '0; bus_ad_i = '0; dma_req = 1'b0;
    step();
    step();
    checkResetValues("reset");
    rst = 1'b0;
    step();

    monEn = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h1234, 8'h00, 1);
    applyStimulus(1'b1, 1'b1, 16'h00C7, 8'h5A, 0);
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    {($urandom_range(0, 1) != 0) ? 8'h12 : 8'h40, 4'h0, 4'($urandom_range(0, 15))},
                    8'($urandom), $urandom_range(0, 2));
    end
    step();
    step();
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);
    checkOutput("err_clean", 32'(bus_err), 32'd0);
    monEn = 1'b0;

    // DMA request raised during a read is held off until the bus is idle
    bus_ale = 1'b1; bus_iom = 1'b0; bus_ahi = 8'h12; bus_ad_i = 8'h34;
    step();
    bus_ale = 1'b0; bus_rd = 1'b1; dma_req = 1'b1;
    step(); step(); step();
    checkOutput("hold_deferred", 32'(core_hold), 32'd0);
    checkOutput("dma_addr", 32'(mem_addr), 32'h1234);
    checkOutput("dma_rdata", 32'(bus_ad_o), 32'(refRead(32'h01234)));
    bus_rd = 1'b0;
    step();
    checkOutput("hold_still_low", 32'(core_hold), 32'd0);
    checkOutput("dma_oe_off", 32'(bus_ad_oe), 32'd0);
    step();
    checkOutput("hold_rise", 32'(core_hold), 32'd1);
    bus_hlda = 1'b1;
    step();
    checkOutput("dma_gnt", 32'(dma_gnt), 32'd1);
    dma_req = 1'b0;
    step();
    checkOutput("hold_fall", 32'(core_hold), 32'd0);
    checkOutput("gnt_fall", 32'(dma_gnt), 32'd0);
    step();
    checkOutput("hlda_ignored", 32'(dma_gnt), 32'd0);
    checkOutput("hlda_no_hold", 32'(core_hold), 32'd0);
    bus_hlda = 1'b0;
    step();
    checkOutput("err_before_proto", 32'(bus_err), 32'd0);

    // ALE during the wait phase of an IO write
    wb = weCount;
    bus_ale = 1'b1; bus_iom = 1'b1; bus_ahi = 8'h30; bus_ad_i = 8'h01;
    step();
    bus_ale = 1'b0; bus_wr = 1'b1; bus_ad_i = 8'h77;
    step();
    checkOutput("io_wait_low", 32'(core_ready), 32'd0);
    step();
    bus_ale = 1'b1; bus_wr = 1'b0; bus_iom = 1'b0; bus_ahi = 8'h56; bus_ad_i = 8'h78;
    step();
    checkOutput("proto_err", 32'(bus_err), 32'd1);
    checkOutput("proto_ready", 32'(core_ready), 32'd1);
    checkOutput("proto_addr", 32'(mem_addr), 32'h5678);
    checkOutput("proto_iom", 32'(mem_iom), 32'd0);
    checkOutput("proto_oe", 32'(bus_ad_oe), 32'd0);
    bus_ale = 1'b0; bus_rd = 1'b1;
    step();
    checkOutput("proto_read_oe", 32'(bus_ad_oe), 32'd1);
    checkOutput("proto_read_data", 32'(bus_ad_o), 32'(refRead(32'h05678)));
    bus_rd = 1'b0;
    step();
    step();
    checkOutput("proto_no_we", 32'(weCount), 32'(wb));
    checkOutput("proto_err_sticky", 32'(bus_err), 32'd1);

    // Reset after one wait cycle of an IO write
    wb = weCount;
    bus_ale = 1'b1; bus_iom = 1'b1; bus_ahi = 8'h31; bus_ad_i = 8'h02;
    step();
    bus_ale = 1'b0; bus_wr = 1'b1; bus_ad_i = 8'h99;
    step();
    step();
    rst = 1'b1;
    #1;
    checkResetValues("midrst");
    bus_wr = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    step();
    checkOutput("midrst_no_we", 32'(weCount), 32'(wb));
    checkOutput("midrst_ready", 32'(core_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
